// File: rtl/alarm_pkg.sv
// alarm_pkg: shared key width, clear-key default and alarm state encoding
package alarm_pkg;
  localparam int KEY_W = 4;
  localparam logic [KEY_W-1:0] CLEAR_DEFAULT = 4'hC;
  typedef enum logic [2:0] {
    DISARMED  = 3'd0,
    EXIT_DLY  = 3'd1,
    ARMED     = 3'd2,
    ENTRY_DLY = 3'd3,
    ALARM     = 3'd4
  } state_t;
endpackage

// File: rtl/code_entry.sv
// code_entry: passcode digit buffer with inter-key timeout and compare on the last digit
module code_entry
  import alarm_pkg::*;
#(
  parameter int                         CODE_LEN    = 4,
  parameter logic [KEY_W*CODE_LEN-1:0]  PASSCODE    = 16'h0965,
  parameter logic [KEY_W-1:0]           CLEAR_CODE  = CLEAR_DEFAULT,
  parameter int                         KEY_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             ok_now,
  output logic             bad_now
);
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int TW = $clog2(KEY_TIMEOUT + 1);
  logic [KEY_W*(CODE_LEN-1)-1:0] digits;
  logic [KEY_W*CODE_LEN-1:0]     word;
  logic [CW-1:0]                 cnt;
  logic [TW-1:0]                 idle;
  logic                          is_clear, last, expire;
  assign is_clear = key_code == CLEAR_CODE;
  assign word     = {digits, key_code};
  assign last     = key_valid && !is_clear && cnt == CW'(CODE_LEN - 1);
  assign expire   = idle == TW'(KEY_TIMEOUT - 1);
  assign ok_now   = last && word == PASSCODE;
  assign bad_now  = last && word != PASSCODE;
  // collect digits; a clear key, a completed entry or an idle timeout empties the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      cnt    <= '0;
      idle   <= '0;
    end else if (key_valid) begin
      idle   <= '0;
      cnt    <= (is_clear || last) ? '0 : cnt + 1'b1;
      digits <= word[KEY_W*(CODE_LEN-1)-1:0];
    end else if (cnt != '0) begin
      idle <= expire ? '0 : idle + 1'b1;
      cnt  <= expire ? '0 : cnt;
    end
  end
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: arming/alarm FSM with timed exit/entry delays and wrong-code lockout
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int                         CODE_LEN       = 4,
  parameter logic [KEY_W*CODE_LEN-1:0]  PASSCODE       = 16'h0965,
  parameter logic [KEY_W-1:0]           CLEAR_CODE     = CLEAR_DEFAULT,
  parameter int                         EXIT_DELAY     = 16,
  parameter int                         ENTRY_DELAY    = 16,
  parameter int                         KEY_TIMEOUT    = 32,
  parameter int                         MAX_FAILS      = 3,
  parameter int                         LOCKOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  input  logic             is_breach,
  output logic             key_accept,
  output logic             is_enabled,
  output logic             led,
  output logic             alert_authorities,
  output logic [2:0]       state_o,
  output logic             code_ok,
  output logic             code_bad,
  output logic             locked
);
  localparam int TMR_W = $clog2((EXIT_DELAY > ENTRY_DELAY ? EXIT_DELAY : ENTRY_DELAY) + 1);
  localparam int FW    = $clog2(MAX_FAILS + 1);
  localparam int LW    = $clog2(LOCKOUT_CYCLES + 1);
  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [FW-1:0]    fail_cnt;
  logic [LW-1:0]    lock_tmr;
  logic             ok_now, bad_now, lock_hit, en_nxt, led_nxt, alert_nxt;
  assign key_accept = !locked;
  assign lock_hit   = bad_now && fail_cnt == FW'(MAX_FAILS - 1);
  assign state_o    = state;
  code_entry #(
    .CODE_LEN(CODE_LEN), .PASSCODE(PASSCODE), .CLEAR_CODE(CLEAR_CODE), .KEY_TIMEOUT(KEY_TIMEOUT)
  ) u_entry (
    .clk(clk), .rst(rst), .key_valid(key_valid && key_accept), .key_code(key_code),
    .ok_now(ok_now), .bad_now(bad_now)
  );
  // state, delay timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= DISARMED;
      tmr               <= '0;
      is_enabled        <= 1'b0;
      led               <= 1'b0;
      alert_authorities <= 1'b0;
      code_ok           <= 1'b0;
      code_bad          <= 1'b0;
    end else begin
      state             <= state_nxt;
      tmr               <= tmr_nxt;
      is_enabled        <= en_nxt;
      led               <= led_nxt;
      alert_authorities <= alert_nxt;
      code_ok           <= ok_now;
      code_bad          <= bad_now;
    end
  end
  // next state: code_ok beats lockout alarm beats timer expiry beats breach
  always_comb begin
    state_nxt = state;
    if (ok_now) state_nxt = (state == DISARMED) ? EXIT_DLY : DISARMED;
    else if (lock_hit && (state == ARMED || state == ENTRY_DLY)) state_nxt = ALARM;
    else if (state == EXIT_DLY && tmr == '0) state_nxt = ARMED;
    else if (state == ENTRY_DLY && tmr == '0) state_nxt = ALARM;
    else if (state == ARMED && is_breach) state_nxt = ENTRY_DLY;
    tmr_nxt = (state_nxt != state) ?
              (state_nxt == EXIT_DLY  ? TMR_W'(EXIT_DELAY - 1)  :
               state_nxt == ENTRY_DLY ? TMR_W'(ENTRY_DELAY - 1) : '0) :
              (tmr != '0 ? tmr - 1'b1 : tmr);
  end
  // outputs decoded from the upcoming state; delays blink the led from the timer
  always_comb begin
    en_nxt    = state_nxt inside {ARMED, ENTRY_DLY, ALARM};
    alert_nxt = state_nxt == ALARM;
    led_nxt   = (state_nxt == ARMED || state_nxt == ALARM) ? 1'b1 :
                (state_nxt == EXIT_DLY || state_nxt == ENTRY_DLY) ? tmr_nxt[2] : 1'b0;
  end
  // consecutive-failure count and lockout window
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= '0;
      lock_tmr <= '0;
      locked   <= 1'b0;
    end else if (locked) begin
      if (lock_tmr == '0) begin
        locked   <= 1'b0;
        fail_cnt <= '0;
      end else lock_tmr <= lock_tmr - 1'b1;
    end else if (ok_now) fail_cnt <= '0;
    else if (bad_now) begin
      fail_cnt <= fail_cnt + 1'b1;
      locked   <= lock_hit;
      lock_tmr <= LW'(LOCKOUT_CYCLES - 1);
    end
  end
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: scoreboard bench for the alarm sequencer with vector table and timed sequences
module tb_alarm_sequencer;
  localparam logic [2:0] D = 3'd0, X = 3'd1, A = 3'd2, N = 3'd3, L = 3'd4;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0, is_breach = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic key_accept, is_enabled, led, alert_authorities, code_ok, code_bad, locked;
  logic [2:0] state_o;
  int errors = 0, checks = 0;
  typedef struct packed {logic [2:0] st; logic ok, bad, en, led, al, lk, ka;} obs_t;
  typedef struct {string name; obs_t o;} exp_t;
  typedef struct {string name; logic kv; logic [3:0] kc; logic [2:0] st; logic ok; logic bad;} vec_t;
  exp_t sb[$];
  vec_t tbl[7];
  logic [15:0] pc = 16'h0965;

  alarm_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .is_breach(is_breach),
    .key_accept(key_accept), .is_enabled(is_enabled), .led(led),
    .alert_authorities(alert_authorities), .state_o(state_o), .code_ok(code_ok),
    .code_bad(code_bad), .locked(locked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic [2:0] st, input logic ok, bad, lk, input int t);
    obs_t o;
    o.st  = st;
    o.ok  = ok;
    o.bad = bad;
    o.en  = st == A || st == N || st == L;
    o.led = (st == A || st == L) ? 1'b1 : (st == X || st == N) ? ((t & 4) != 0) : 1'b0;
    o.al  = st == L;
    o.lk  = lk;
    o.ka  = !lk;
    return o;
  endfunction

  task automatic tick(input string name, input logic kv, input logic [3:0] kc, input logic br, input obs_t e);
    exp_t x;
    obs_t got;
    key_valid = kv;
    key_code  = kc;
    is_breach = br;
    x.name = name;
    x.o    = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x   = sb.pop_front();
    got = {state_o, code_ok, code_bad, is_enabled, led, alert_authorities, locked, key_accept};
    checks++;
    if (got !== x.o) begin
      errors++;
      $display("FAIL %s: got st/ok/bad/en/led/al/lk/ka=%b want %b", x.name, got, x.o);
    end
    key_valid = 1'b0;
    is_breach = 1'b0;
  endtask

  task automatic key(input string name, input logic [3:0] k, input logic [2:0] st, input logic ok, bad, lk, input int t);
    tick(name, 1'b1, k, 1'b0, mk(st, ok, bad, lk, t));
  endtask

  task automatic code4(input string name, input logic [15:0] c, input logic [2:0] s0, s1, input logic ok, bad, lk, input int t);
    for (int i = 0; i < 3; i++) key(name, c[15-4*i -: 4], s0, 1'b0, 1'b0, 1'b0, 0);
    key(name, c[3:0], s1, ok, bad, lk, t);
  endtask

  task automatic hold(input string name, input int n, input logic [2:0] st, input logic lk);
    repeat (n) tick(name, 1'b0, 4'h0, 1'b0, mk(st, 1'b0, 1'b0, lk, 0));
  endtask

  task automatic delay(input string name, input logic [2:0] st, input int from, input int to);
    for (int i = from; i >= to; i--) tick(name, 1'b0, 4'h0, 1'b0, mk(st, 1'b0, 1'b0, 1'b0, i));
  endtask

  task automatic arm();
    code4("arm code", 16'h0965, D, X, 1'b1, 1'b0, 1'b0, 15);
    delay("exit delay", X, 14, 0);
    tick("armed", 1'b0, 4'h0, 1'b0, mk(A, 1'b0, 1'b0, 1'b0, 0));
  endtask

  task automatic cancel();
    key("cancel", 4'h0, X, 1'b0, 1'b0, 1'b0, 14);
    key("cancel", 4'h9, X, 1'b0, 1'b0, 1'b0, 13);
    key("cancel", 4'h6, X, 1'b0, 1'b0, 1'b0, 12);
    key("cancel", 4'h5, D, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic lockwait(input string name, input logic [2:0] st);
    for (int i = 0; i < 63; i++)
      tick(name, 1'b1, pc[15-4*(i%4) -: 4], 1'b0, mk(st, 1'b0, 1'b0, 1'b1, 0));
    tick({name, " release"}, 1'b0, 4'h0, 1'b0, mk(st, 1'b0, 1'b0, 1'b0, 0));
  endtask

  initial begin
    tbl[0] = '{"clr seq 0", 1'b1, 4'h0, D, 1'b0, 1'b0};
    tbl[1] = '{"clr seq C", 1'b1, 4'hC, D, 1'b0, 1'b0};
    tbl[2] = '{"clr seq idle", 1'b0, 4'h0, D, 1'b0, 1'b0};
    tbl[3] = '{"clr seq 0b", 1'b1, 4'h0, D, 1'b0, 1'b0};
    tbl[4] = '{"clr seq 9", 1'b1, 4'h9, D, 1'b0, 1'b0};
    tbl[5] = '{"clr seq 6", 1'b1, 4'h6, D, 1'b0, 1'b0};
    tbl[6] = '{"clr seq 5", 1'b1, 4'h5, X, 1'b1, 1'b0};
    rst = 1'b1;
    tick("reset", 1'b0, 4'h0, 1'b0, mk(D, 1'b0, 1'b0, 1'b0, 0));
    tick("reset", 1'b1, 4'h0, 1'b1, mk(D, 1'b0, 1'b0, 1'b0, 0));
    rst = 1'b0;
    hold("idle", 2, D, 1'b0);
    arm();
    hold("armed hold", 3, A, 1'b0);
    tick("breach", 1'b0, 4'h0, 1'b1, mk(N, 1'b0, 1'b0, 1'b0, 15));
    delay("entry delay", N, 14, 0);
    tick("alarm", 1'b0, 4'h0, 1'b0, mk(L, 1'b0, 1'b0, 1'b0, 0));
    hold("alarm hold", 3, L, 1'b0);
    code4("disarm alarm", 16'h0965, L, D, 1'b1, 1'b0, 1'b0, 0);
    hold("disarmed", 2, D, 1'b0);
    arm();
    tick("breach", 1'b0, 4'h0, 1'b1, mk(N, 1'b0, 1'b0, 1'b0, 15));
    delay("entry delay", N, 14, 3);
    key("race", 4'h0, N, 1'b0, 1'b0, 1'b0, 2);
    key("race", 4'h9, N, 1'b0, 1'b0, 1'b0, 1);
    key("race", 4'h6, N, 1'b0, 1'b0, 1'b0, 0);
    key("race ok vs expiry", 4'h5, D, 1'b1, 1'b0, 1'b0, 0);
    hold("no alarm", 3, D, 1'b0);
    arm();
    code4("armed bad1", 16'h1111, A, A, 1'b0, 1'b1, 1'b0, 0);
    code4("armed bad2", 16'h1111, A, A, 1'b0, 1'b1, 1'b0, 0);
    code4("armed bad3", 16'h1111, A, L, 1'b0, 1'b1, 1'b1, 0);
    lockwait("alarm lockout", L);
    code4("disarm after lock", 16'h0965, L, D, 1'b1, 1'b0, 1'b0, 0);
    code4("bad1", 16'h1111, D, D, 1'b0, 1'b1, 1'b0, 0);
    code4("bad2", 16'h1111, D, D, 1'b0, 1'b1, 1'b0, 0);
    code4("bad3", 16'h1111, D, D, 1'b0, 1'b1, 1'b1, 0);
    lockwait("lockout", D);
    code4("post lock bad1", 16'h1111, D, D, 1'b0, 1'b1, 1'b0, 0);
    code4("post lock bad2", 16'h1111, D, D, 1'b0, 1'b1, 1'b0, 0);
    code4("good", 16'h0965, D, X, 1'b1, 1'b0, 1'b0, 15);
    cancel();
    key("partial", 4'h0, D, 1'b0, 1'b0, 1'b0, 0);
    key("partial", 4'h9, D, 1'b0, 1'b0, 1'b0, 0);
    hold("timeout", 32, D, 1'b0);
    code4("after timeout", 16'h6509, D, D, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 7; i++)
      tick(tbl[i].name, tbl[i].kv, tbl[i].kc, 1'b0, mk(tbl[i].st, tbl[i].ok, tbl[i].bad, 1'b0, 15));
    cancel();
    key("slow", 4'h0, D, 1'b0, 1'b0, 1'b0, 0);
    key("slow", 4'h9, D, 1'b0, 1'b0, 1'b0, 0);
    hold("under timeout", 31, D, 1'b0);
    key("slow", 4'h6, D, 1'b0, 1'b0, 1'b0, 0);
    key("slow ok", 4'h5, X, 1'b1, 1'b0, 1'b0, 15);
    delay("exit delay", X, 14, 10);
    rst = 1'b1;
    tick("rst mid exit", 1'b0, 4'h0, 1'b0, mk(D, 1'b0, 1'b0, 1'b0, 0));
    rst = 1'b0;
    hold("after rst", 3, D, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
